// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester/memory side bundle of the shared data-memory arbiter.
// The slave modport is the arbiter; the master modport is everything around it
// (the requesting masters plus the memory read-data return).
interface dmem_arbiter_if #(
    parameter int NREQ = 4,
    parameter int wide = 32
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      lock;
    logic [NREQ-1:0]      we_in;
    logic [NREQ*32-1:0]   addr_in;
    logic [NREQ*wide-1:0] wd_in;
    logic [NREQ-1:0]      gnt;
    logic [2:0]           owner;
    logic                 dm_we;
    logic [31:0]          dm_a;
    logic [wide-1:0]      dm_d;
    logic [wide-1:0]      dm_q;
    logic [wide-1:0]      rd_data;
    logic                 timeout;

    modport master (
        output req, lock, we_in, addr_in, wd_in, dm_q,
        input  gnt, owner, dm_we, dm_a, dm_d, rd_data, timeout
    );

    modport slave (
        input  req, lock, we_in, addr_in, wd_in, dm_q,
        output gnt, owner, dm_we, dm_a, dm_d, rd_data, timeout
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one data-memory port among NREQ masters.
// Registered one-hot grant, one idle turnaround cycle between owners, optional
// lock for bursts. Define ARB_TIMEOUT_EN to force release of a locked owner
// after MAX_HOLD grant cycles when another master is waiting.
module dmem_arbiter #(
    parameter int NREQ     = 4,
    parameter int wide     = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam int HoldW = $clog2(MAX_HOLD) + 1;

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    state_e          r_state, w_state_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [2:0]      r_owner, w_owner_nxt;
    logic [2:0]      w_winner;

    // Zero-extended copies so the 3-bit owner index is always in range.
    logic [7:0]      w_req_ext, w_lock_ext, w_we_ext, w_gnt_ext;
    logic            w_any_req, w_own_req, w_own_lock, w_other_req, w_granted;
    logic [31:0]     w_sel_a;
    logic [wide-1:0] w_sel_d;

`ifdef ARB_TIMEOUT_EN
    logic [HoldW-1:0] r_hold_cnt, w_hold_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             w_hold_max;
    assign w_hold_max = (r_hold_cnt == HoldW'(MAX_HOLD - 1));
`else
    logic [HoldW-1:0] w_unused_hold;
    assign w_unused_hold = '0;
`endif

    assign w_req_ext   = 8'(bus.req);
    assign w_lock_ext  = 8'(bus.lock);
    assign w_we_ext    = 8'(bus.we_in);
    assign w_gnt_ext   = 8'(r_gnt);
    assign w_any_req   = |bus.req;
    assign w_own_req   = w_req_ext[r_owner];
    assign w_own_lock  = w_lock_ext[r_owner];
    assign w_granted   = w_gnt_ext[r_owner];
    assign w_other_req = |(w_req_ext & ~(8'b1 << r_owner));

    // Round-robin pick: first requester after the current owner, wrapping.
    always_comb begin : p_winner
        logic [2:0] v_idx;
        logic       v_found;
        v_idx    = '0;
        v_found  = 1'b0;
        w_winner = r_owner;
        for (int i = 1; i <= NREQ; i++) begin
            v_idx = 3'((int'(r_owner) + i) % NREQ);
            if (!v_found && w_req_ext[v_idx]) begin
                v_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    // Select the owner's address and write data lanes.
    always_comb begin : p_lane_mux
        w_sel_a = '0;
        w_sel_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == 3'(i)) begin
                w_sel_a = bus.addr_in[32*i +: 32];
                w_sel_d = bus.wd_in[wide*i +: wide];
            end
        end
    end

    // Next-state logic: arbitrate in IDLE/GAP, decide release in GRANT.
    always_comb begin : p_next
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
`ifdef ARB_TIMEOUT_EN
        w_hold_nxt    = r_hold_cnt;
        w_timeout_nxt = 1'b0;
`endif
        unique case (r_state)
            StIdle, StGap: begin
                if (w_any_req) begin
                    w_state_nxt = StGrant;
                    w_gnt_nxt   = NREQ'(8'b1 << w_winner);
                    w_owner_nxt = w_winner;
`ifdef ARB_TIMEOUT_EN
                    w_hold_nxt  = '0;
`endif
                end else begin
                    w_state_nxt = StIdle;
                    w_gnt_nxt   = '0;
                end
            end
            StGrant: begin
                if (!w_own_req || (!w_own_lock && w_other_req)) begin
                    w_state_nxt = StGap;
                    w_gnt_nxt   = '0;
`ifdef ARB_TIMEOUT_EN
                    w_hold_nxt  = '0;
                end else if (w_hold_max && w_other_req) begin
                    // Locked owner overstayed while someone waits.
                    w_state_nxt   = StGap;
                    w_gnt_nxt     = '0;
                    w_hold_nxt    = '0;
                    w_timeout_nxt = 1'b1;
                end else if (!w_hold_max) begin
                    w_hold_nxt = r_hold_cnt + HoldW'(1);
`endif
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_gnt      <= '0;
            r_owner    <= 3'(NREQ - 1);
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_owner    <= w_owner_nxt;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt <= w_hold_nxt;
            r_timeout  <= w_timeout_nxt;
`endif
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.owner   = r_owner;
    // rst gating suppresses a write that would land on the reset edge.
    assign bus.dm_we   = ~rst & w_granted & w_own_req & w_we_ext[r_owner];
    assign bus.dm_a    = w_granted ? w_sel_a : '0;
    assign bus.dm_d    = w_granted ? w_sel_d : '0;
    assign bus.rd_data = bus.dm_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus randomized checks of dmem_arbiter against a
// cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;
    localparam int NREQ     = 4;
    localparam int WIDE     = 32;
    localparam int MAX_HOLD = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.NREQ(NREQ), .wide(WIDE)) bus ();

    dmem_arbiter #(.NREQ(NREQ), .wide(WIDE), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory seen by the DUT, and the reference copy kept by the model.
    logic [31:0] ram     [0:63];
    logic [31:0] ram_ref [0:63];
    assign bus.dm_q = ram[bus.dm_a[7:2]];
    always @(posedge clk) if (bus.dm_we) ram[bus.dm_a[7:2]] <= bus.dm_d;

    int n_tests;
    int n_fail;
    logic [NREQ-1:0] obs_gnt;

    // Reference model state: is someone granted, who, how long, timeout pulse.
    bit m_busy;
    int m_owner;
    int m_hold;
    bit m_tmo;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pick(int last, logic [NREQ-1:0] r);
        for (int i = 1; i <= NREQ; i++) begin
            if (r[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return last;
    endfunction

    // One clock: check outputs at negedge, advance the model, return at posedge+1.
    task automatic step(string tag);
        logic [NREQ-1:0] e_gnt;
        logic            e_we;
        logic [31:0]     e_a;
        logic [31:0]     e_d;
        bit              others;
        @(negedge clk);
        obs_gnt = bus.gnt;
        e_gnt = '0;
        if (m_busy) e_gnt[m_owner] = 1'b1;
        e_we = m_busy && bus.req[m_owner] && bus.we_in[m_owner] && !rst;
        e_a  = m_busy ? bus.addr_in[32*m_owner +: 32] : 32'h0;
        e_d  = m_busy ? bus.wd_in[WIDE*m_owner +: WIDE] : 32'h0;
        check({tag, " gnt"},     32'(bus.gnt),     32'(e_gnt));
        check({tag, " owner"},   32'(bus.owner),   32'(m_owner));
        check({tag, " dm_we"},   32'(bus.dm_we),   32'(e_we));
        check({tag, " dm_a"},    bus.dm_a,         e_a);
        check({tag, " dm_d"},    bus.dm_d,         e_d);
        check({tag, " rd_data"}, bus.rd_data,      ram_ref[e_a[7:2]]);
        check({tag, " timeout"}, 32'(bus.timeout), 32'(m_tmo));
        if (e_we) ram_ref[e_a[7:2]] = e_d;
        if (rst) begin
            m_busy = 0; m_owner = NREQ - 1; m_hold = 0; m_tmo = 0;
        end else if (!m_busy) begin
            m_tmo = 0;
            if (bus.req != '0) begin
                m_owner = pick(m_owner, bus.req);
                m_busy  = 1;
                m_hold  = 0;
            end
        end else begin
            others = (bus.req & ~(NREQ'(1) << m_owner)) != '0;
            m_tmo  = 0;
            if (!bus.req[m_owner]) m_busy = 0;
            else if (!bus.lock[m_owner] && others) m_busy = 0;
            else if (TMO_EN && m_hold == MAX_HOLD - 1 && others) begin
                m_busy = 0;
                m_tmo  = 1;
            end else if (m_hold < MAX_HOLD - 1) m_hold++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step("rst");
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_seq [0:8];
        int acc [0:NREQ-1];
        int cnt;
        bit run;
        n_tests = 0;
        n_fail  = 0;
        m_busy = 0; m_owner = NREQ - 1; m_hold = 0; m_tmo = 0;
        for (int i = 0; i < 64; i++) begin
            ram[i]     <= 32'(i) * 32'h0101_0101;
            ram_ref[i] = 32'(i) * 32'h0101_0101;
        end
        bus.req = '0; bus.lock = '0; bus.we_in = '0; bus.addr_in = '0; bus.wd_in = '0;

        // Reset state
        rst = 1'b1;
        step("t1a");
        step("t1b");
        check("t1 owner", 32'(bus.owner), 32'(NREQ - 1));
        check("t1 gnt",   32'(bus.gnt),   32'h0);
        rst = 1'b0;

        // Single write by master 0
        bus.req = 4'b0001; bus.we_in = 4'b0001;
        bus.addr_in[31:0] = 32'h40; bus.wd_in[31:0] = 32'hDEAD_BEEF;
        step("t2a");
        check("t2 gnt",   32'(bus.gnt), 32'h1);
        check("t2 dm_we", 32'(bus.dm_we), 32'h1);
        check("t2 dm_a",  bus.dm_a, 32'h40);
        check("t2 dm_d",  bus.dm_d, 32'hDEAD_BEEF);
        step("t2b");
        check("t2 ram", ram[16], 32'hDEAD_BEEF);
        bus.req = '0; bus.we_in = '0;
        step("t2c");
        step("t2d");

        // All request, no lock: strict rotation with a gap between owners
        do_reset();
        bus.req = 4'b1111; bus.lock = '0;
        exp_seq = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        for (int j = 0; j < NREQ; j++) acc[j] = 0;
        step("t3_arb");
        for (int k = 0; k < 9; k++) begin
            step("t3");
            check($sformatf("t3 seq%0d", k), 32'(obs_gnt), 32'(exp_seq[k]));
            for (int j = 0; j < NREQ; j++) if (k < 8 && obs_gnt[j]) acc[j]++;
        end
        for (int j = 0; j < NREQ; j++) check($sformatf("t3 acc%0d", j), acc[j], 1);

        // Locked burst against a waiting master
        do_reset();
        bus.req = 4'b0011; bus.lock = 4'b0001;
        step("t4_arb");
        cnt = 0; run = 1;
        for (int k = 0; k < 30; k++) begin
            step("t4");
            if (run && obs_gnt == 4'b0001) cnt++;
            else run = 0;
        end
        check("t4 hold", cnt, TMO_EN ? MAX_HOLD : 30);
        bus.req = 4'b0010;
        for (int k = 0; k < 4; k++) step("t4_end");

        // Reset in the middle of a locked write burst
        do_reset();
        bus.req = 4'b0100; bus.lock = 4'b0100; bus.we_in = 4'b0100;
        bus.addr_in[95:64] = 32'h80; bus.wd_in[95:64] = 32'h1234_5678;
        step("t5a");
        step("t5b");
        bus.wd_in[95:64] = 32'hCAFE_F00D;
        rst = 1'b1;
        step("t5_rst");
        rst = 1'b0;
        check("t5 ram",   ram[32], 32'h1234_5678);
        check("t5 gnt0",  32'(bus.gnt), 32'h0);
        check("t5 we0",   32'(bus.dm_we), 32'h0);
        step("t5c");
        check("t5 regnt", 32'(bus.gnt), 32'h4);

        // Owner 1 drops while master 3 rises on the same edge
        do_reset();
        bus.req = 4'b0010; bus.lock = 4'b0010; bus.we_in = '0;
        step("t6a");
        step("t6b");
        bus.req = 4'b1000; bus.lock = 4'b1000;
        step("t6c");
        check("t6 gap", 32'(bus.gnt), 32'h0);
        step("t6d");
        check("t6 gnt3", 32'(bus.gnt), 32'h8);

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0) bus.req = NREQ'($urandom);
            if ($urandom_range(0, 7) == 0) bus.lock = NREQ'($urandom);
            bus.we_in = NREQ'($urandom);
            for (int j = 0; j < NREQ; j++) begin
                bus.addr_in[32*j +: 32] = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                bus.wd_in[WIDE*j +: WIDE] = $urandom;
            end
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
